// File: rtl/posit_pkg.sv
// Shared types and constants for the posit accumulator slice.
package posit_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int MAX_BITS = 64;

    // Callers truncate to their own BITS; the set bit sits at BITS-1.
    function automatic logic [MAX_BITS-1:0] nar_const(input int bits);
        return {{(MAX_BITS-1){1'b0}}, 1'b1} << (bits - 1);
    endfunction

    // Zero is the NaR pattern with its sign bit cleared.
    function automatic logic [MAX_BITS-1:0] zero_const(input int bits);
        return nar_const(bits) & ~nar_const(bits);
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational posit adder: round-to-nearest-even on the encoded bit string,
// results saturate at minpos/maxpos, NaR absorbs, zero passes the other operand.
module adder #(
    parameter int BITS = 32,
    parameter int ES   = 3
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] sum
);
    import posit_pkg::*;

    localparam int FW = BITS - ES;
    localparam int AW = 2 * FW + 2;
    localparam int LW = BITS + ES + AW + 2;
    localparam logic [BITS-1:0] NAR  = BITS'(nar_const(BITS));
    localparam logic [BITS-1:0] ZERO = BITS'(zero_const(BITS));
    localparam logic signed [15:0] K_MAX = 16'(BITS - 2);
    localparam logic signed [15:0] K_MIN = -K_MAX;
    localparam logic signed [15:0] AW_S  = 16'(AW);

    typedef struct packed {
        logic               sign;
        logic signed [15:0] scale;
        logic [FW-2:0]      frac;
    } dec_t;

    function automatic dec_t decode(input logic [BITS-1:0] x);
        dec_t d;
        logic [BITS-2:0] r;
        logic [BITS-2:0] rem;
        int run;
        int k;
        logic stop;
        d.sign = x[BITS-1];
        // Low bits of the negation depend only on the low bits.
        r = x[BITS-1] ? -x[BITS-2:0] : x[BITS-2:0];
        run = 0;
        stop = 1'b0;
        for (int i = BITS - 2; i >= 0; i--) begin
            if (!stop && r[i] == r[BITS-2]) run++;
            else stop = 1'b1;
        end
        k = r[BITS-2] ? run - 1 : -run;
        rem = r << (run + 1);
        d.scale = 16'(k * (1 << ES) + int'(rem[BITS-2 -: ES]));
        d.frac = rem[FW-2:0];
        return d;
    endfunction

    function automatic int lead_pos(input logic [AW:0] s);
        int p;
        p = 0;
        for (int i = 0; i <= AW; i++) begin
            if (s[i]) p = i;
        end
        return p;
    endfunction

    function automatic logic [BITS-1:0] encode(input logic sign,
                                               input logic signed [15:0] scale,
                                               input logic [AW-1:0] frac);
        logic signed [15:0] k;
        logic [ES-1:0] e;
        logic signed [LW-1:0] xs;
        logic [LW-1:0] t;
        logic [BITS-2:0] body;
        logic guard;
        logic sticky;
        logic up;
        logic [BITS-1:0] mag;
        k = scale >>> ES;
        e = scale[ES-1:0];
        xs = '0;
        t = '0;
        if (k >= K_MAX) begin
            body = '1;
        end else if (k < K_MIN) begin
            body = {{(BITS-2){1'b0}}, 1'b1};
        end else begin
            // Regime is built by shifting in copies of its leading bit.
            if (k >= 0) begin
                xs = {2'b10, e, frac, {BITS{1'b0}}};
                t = xs >>> k;
            end else begin
                t = {2'b01, e, frac, {BITS{1'b0}}};
                t = t >> (-k - 16'sd1);
            end
            body = t[LW-1 -: BITS-1];
            guard = t[LW-BITS];
            sticky = |t[LW-BITS-1:0];
            up = guard & (sticky | body[0]);
            body = body + {{(BITS-2){1'b0}}, up};
        end
        mag = {1'b0, body};
        return sign ? -mag : mag;
    endfunction

    logic [BITS-1:0] mag_a;
    logic [BITS-1:0] mag_b;
    logic            swap;
    dec_t            da;
    dec_t            db;
    logic signed [15:0] diff;
    logic [AW-1:0]   ma;
    logic [AW-1:0]   mb;
    logic [AW-1:0]   mb_sh;
    logic [AW:0]     s;
    int              lead;
    logic [BITS-1:0] sum_enc;

    always_comb begin
        mag_a = a[BITS-1] ? -a : a;
        mag_b = b[BITS-1] ? -b : b;
        // Posit magnitudes order like integers, so the larger operand is found directly.
        swap = mag_b > mag_a;
        da = decode(swap ? b : a);
        db = decode(swap ? a : b);
        diff = $signed(da.scale) - $signed(db.scale);
        ma = {1'b1, da.frac, {(AW-FW){1'b0}}};
        mb = {1'b1, db.frac, {(AW-FW){1'b0}}};
        if (diff >= AW_S) begin
            mb_sh = {{(AW-1){1'b0}}, 1'b1};
        end else begin
            mb_sh = (mb >> diff) | {{(AW-1){1'b0}}, |(mb & ~({AW{1'b1}} << diff))};
        end
        if (da.sign == db.sign) s = {1'b0, ma} + {1'b0, mb_sh};
        else                    s = {1'b0, ma} - {1'b0, mb_sh};
        lead = lead_pos(s);
        sum_enc = encode(da.sign, $signed(da.scale) + 16'(lead) - 16'(AW - 1),
                         AW'(s << (AW - lead)));

        if (a == NAR || b == NAR) sum = NAR;
        else if (a == ZERO)       sum = b;
        else if (b == ZERO)       sum = a;
        else if (s == '0)         sum = ZERO;
        else                      sum = sum_enc;
    end

endmodule

// File: rtl/posit_in_slice.sv
// One-entry input register slice (data, last) in front of the adder.
// Only built when POSIT_ACC_INPUT_REG_EN is defined.
`ifdef POSIT_ACC_INPUT_REG_EN
module posit_in_slice #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            in_ready,
    input  logic            accum_en,
    output logic            beat_valid,
    output logic [BITS-1:0] beat_data,
    output logic            beat_last
);
    logic            vld_p1;
    logic [BITS-1:0] data_p1;
    logic            last_p1;

    // A held last beat blocks the port until the packet result is handed off.
    assign in_ready   = accum_en & ~(vld_p1 & last_p1);
    assign beat_valid = vld_p1 & accum_en;
    assign beat_data  = data_p1;
    assign beat_last  = last_p1;

    // Port -> p1 register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (in_valid && in_ready) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data;
            last_p1 <= in_last;
        end else if (beat_valid) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/posit_accumulator.sv
// Streaming posit packet accumulator feeding a single combinational adder.
// Define POSIT_ACC_INPUT_REG_EN to insert a register slice between the port and the adder.
module posit_accumulator #(
    parameter int BITS  = 32,
    parameter int ES    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nar
);
    import posit_pkg::*;

    localparam logic [BITS-1:0] NAR  = BITS'(nar_const(BITS));
    localparam logic [BITS-1:0] ZERO = BITS'(zero_const(BITS));

    state_t           state;
    logic [BITS-1:0]  acc;
    logic [CNT_W-1:0] count;
    logic             nar;

    logic             accum_en;
    logic             beat_vld;
    logic [BITS-1:0]  beat_data;
    logic             beat_last;
    logic [BITS-1:0]  sum_w;
    logic             nar_next;
    logic [CNT_W-1:0] count_next;

    assign accum_en = (state == ACCUM);

`ifdef POSIT_ACC_INPUT_REG_EN
    posit_in_slice #(
        .BITS(BITS)
    ) u_in_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .accum_en  (accum_en),
        .beat_valid(beat_vld),
        .beat_data (beat_data),
        .beat_last (beat_last)
    );
`else
    assign in_ready  = accum_en;
    assign beat_vld  = in_valid & accum_en;
    assign beat_data = in_data;
    assign beat_last = in_last;
`endif

    adder #(
        .BITS(BITS),
        .ES  (ES)
    ) u_adder (
        .a  (acc),
        .b  (beat_data),
        .sum(sum_w)
    );

    assign nar_next   = nar | (beat_data == NAR);
    assign count_next = (&count) ? count : count + CNT_W'(1);

    // Beat -> accumulator register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= ZERO;
            count <= '0;
            nar   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat_vld) begin
                        // Once NaR is seen the sum is pinned to NaR for the rest of the packet.
                        acc   <= nar_next ? NAR : sum_w;
                        count <= count_next;
                        nar   <= nar_next;
                        if (beat_last) state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= ZERO;
                        count <= '0;
                        nar   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_count = count;
    assign out_nar   = nar;

endmodule

// File: tb/tb_posit_accumulator.sv
// Directed-vector bench for posit_accumulator at BITS=16, ES=1, CNT_W=4.
module tb_posit_accumulator;
    localparam int BITS  = 16;
    localparam int ES    = 1;
    localparam int CNT_W = 4;
`ifdef POSIT_ACC_INPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_nar;

    int n_vec = 0;
    int n_err = 0;

    posit_accumulator #(
        .BITS (BITS),
        .ES   (ES),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_nar  (out_nar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_beat(input logic [BITS-1:0] d, input logic last);
        int wait_c;
        wait_c = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        while (!in_ready && wait_c < 50) begin
            @(posedge clk); #1;
            wait_c++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_beat: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, out_sum, out_count, out_nar} !== {1'b0, 1'b1, 16'h0000, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got valid=%b ready=%b sum=%h count=%0d nar=%b, required 0 1 0000 0 0",
                     out_valid, in_ready, out_sum, out_count, out_nar);
        end
    endtask

    task automatic test_single();
        int cyc;
        send_beat(16'h4000, 1'b1);
        idle();
        wait_result(cyc);
        n_vec++;
        if (cyc !== LAT) begin
            n_err++;
            $display("FAIL single latency: got %0d extra cycles, required %0d", cyc, LAT);
        end
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h4000, 4'd1, 1'b0}) begin
            n_err++;
            $display("FAIL single result: got valid=%b sum=%h count=%0d nar=%b, required 1 4000 1 0",
                     out_valid, out_sum, out_count, out_nar);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({out_valid, in_ready, out_count} !== {1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL single return: got valid=%b ready=%b count=%0d, required 0 1 0",
                     out_valid, in_ready, out_count);
        end
    endtask

    task automatic test_three_beat();
        int cyc;
        send_beat(16'h4000, 1'b0);
        send_beat(16'h4000, 1'b0);
        send_beat(16'h5000, 1'b1);
        idle();
        wait_result(cyc);
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h6000, 4'd3, 1'b0}) begin
            n_err++;
            $display("FAIL three_beat: got valid=%b sum=%h count=%0d nar=%b, required 1 6000 3 0",
                     out_valid, out_sum, out_count, out_nar);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cancel();
        int cyc;
        send_beat(16'h4000, 1'b0);
        send_beat(16'hC000, 1'b1);
        idle();
        wait_result(cyc);
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h0000, 4'd2, 1'b0}) begin
            n_err++;
            $display("FAIL cancel: got valid=%b sum=%h count=%0d nar=%b, required 1 0000 2 0",
                     out_valid, out_sum, out_count, out_nar);
        end
        @(posedge clk); #1;
    endtask

    // 2 + (-1) = 1.0 (0x4000), then 1.0 + 0.5 = 1.5 (0x4800) as a second packet.
    task automatic test_back_to_back();
        int cyc;
        send_beat(16'h5000, 1'b0);
        send_beat(16'hC000, 1'b1);
        idle();
        wait_result(cyc);
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h4000, 4'd2, 1'b0}) begin
            n_err++;
            $display("FAIL mixed_sign: got valid=%b sum=%h count=%0d nar=%b, required 1 4000 2 0",
                     out_valid, out_sum, out_count, out_nar);
        end
        @(posedge clk); #1;
        send_beat(16'h4000, 1'b0);
        send_beat(16'h3000, 1'b1);
        idle();
        wait_result(cyc);
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h4800, 4'd2, 1'b0}) begin
            n_err++;
            $display("FAIL one_and_half: got valid=%b sum=%h count=%0d nar=%b, required 1 4800 2 0",
                     out_valid, out_sum, out_count, out_nar);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nar();
        int cyc;
        send_beat(16'h4000, 1'b0);
        send_beat(16'h8000, 1'b0);
        send_beat(16'h5000, 1'b1);
        idle();
        wait_result(cyc);
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h8000, 4'd3, 1'b1}) begin
            n_err++;
            $display("FAIL nar_sticky: got valid=%b sum=%h count=%0d nar=%b, required 1 8000 3 1",
                     out_valid, out_sum, out_count, out_nar);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) send_beat(16'h0000, (i == 19));
        idle();
        wait_result(cyc);
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h0000, 4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL saturate: got valid=%b sum=%h count=%0d nar=%b, required 1 0000 15 0",
                     out_valid, out_sum, out_count, out_nar);
        end
        // Offer a beat during the stall; it must not be taken.
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_ready[%0d]: got %b, required 0", i, in_ready);
            end
            n_vec++;
            if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h0000, 4'd15, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got valid=%b sum=%h count=%0d nar=%b, required 1 0000 15 0",
                         i, out_valid, out_sum, out_count, out_nar);
            end
        end
        idle();
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({out_valid, in_ready, out_count} !== {1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL stall_release: got valid=%b ready=%b count=%0d, required 0 1 0",
                     out_valid, in_ready, out_count);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        send_beat(16'h4000, 1'b0);
        send_beat(16'h4000, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, out_sum, out_count, out_nar} !== {1'b0, 1'b1, 16'h0000, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset_clear: got valid=%b ready=%b sum=%h count=%0d nar=%b, required 0 1 0000 0 0",
                     out_valid, in_ready, out_sum, out_count, out_nar);
        end
        send_beat(16'h5000, 1'b1);
        idle();
        wait_result(cyc);
        n_vec++;
        if ({out_valid, out_sum, out_count, out_nar} !== {1'b1, 16'h5000, 4'd1, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset_packet: got valid=%b sum=%h count=%0d nar=%b, required 1 5000 1 0",
                     out_valid, out_sum, out_count, out_nar);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_three_beat();
        test_cancel();
        test_back_to_back();
        test_nar();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
